// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive buffer: byte width, default FIFO
// geometry and the default idle-timeout length.
package uart_rx_fifo_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DEF_DEPTH          = 16;
    localparam int unsigned DEF_ADDR_W         = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 50000;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: generic single-clock show-ahead FIFO. Pointers wrap naturally
// at DEPTH (power of two); the fill count is kept in its own register so
// that full and empty are unambiguous. A write while full is accepted only
// when a read completes on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Qualify requests: reads need data, writes need space or a same-edge read.
    always_comb begin
        do_rd = rd_en && !empty;
        do_wr = wr_en && (!full || do_rd);
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and fill-count update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer behind the UART receiver. A rising edge
// of the receiver's done level writes the byte into sync_fifo; bytes leave on
// a valid/ready stream. Reports fill level, full and a sticky overflow flag.
// Optional idle timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined;
// otherwise o_Timeout is tied low.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              i_SysClock,
    input  logic              i_Reset,
    input  logic [BYTE_W-1:0] i_RxByte,
    input  logic              i_RxDone,
    output logic [BYTE_W-1:0] o_Data,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Full,
    output logic              o_Overflow,
    input  logic              i_ClearOverflow,
    output logic              o_Timeout
);

    if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : g_bad_geometry
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_rx_fifo: TIMEOUT_CYCLES must be at least 1");
    end

    logic done_q;
    logic wr_evt;
    logic rd_evt;
    logic drop;
    logic fifo_empty;
    logic fifo_full;

    // done_q resets high so the receiver's idle-high done is not seen as an edge.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            done_q <= 1'b1;
        end else begin
            done_q <= i_RxDone;
        end
    end

    assign wr_evt  = i_RxDone && !done_q;
    assign rd_evt  = !fifo_empty && i_Ready;
    assign drop    = wr_evt && fifo_full && !rd_evt;
    assign o_Valid = !fifo_empty;
    assign o_Full  = fifo_full;

    sync_fifo #(
        .WIDTH  (BYTE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (i_SysClock),
        .rst     (i_Reset),
        .wr_en   (wr_evt),
        .wr_data (i_RxByte),
        .rd_en   (rd_evt),
        .rd_data (o_Data),
        .count   (o_Count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            o_Overflow <= 1'b0;
        end else if (drop) begin
            o_Overflow <= 1'b1;
        end else if (i_ClearOverflow) begin
            o_Overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] idle_cnt;

    // Idle counter: runs while data waits untouched, saturates at the limit.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset || fifo_empty || wr_evt || rd_evt) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign o_Timeout = (idle_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
    assign o_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH 16, TIMEOUT_CYCLES 10). Inputs are
// driven 1 time unit after each rising edge; outputs are checked there too.
module tb_uart_rx_fifo;

    logic       i_SysClock = 1'b0;
    logic       i_Reset;
    logic [7:0] i_RxByte;
    logic       i_RxDone;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       i_Ready;
    logic [4:0] o_Count;
    logic       o_Full;
    logic       o_Overflow;
    logic       i_ClearOverflow;
    logic       o_Timeout;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]  q[$];

    always #5 i_SysClock = ~i_SysClock;

    uart_rx_fifo #(
        .DEPTH          (16),
        .ADDR_W         (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .i_SysClock      (i_SysClock),
        .i_Reset         (i_Reset),
        .i_RxByte        (i_RxByte),
        .i_RxDone        (i_RxDone),
        .o_Data          (o_Data),
        .o_Valid         (o_Valid),
        .i_Ready         (i_Ready),
        .o_Count         (o_Count),
        .o_Full          (o_Full),
        .o_Overflow      (o_Overflow),
        .i_ClearOverflow (i_ClearOverflow),
        .o_Timeout       (o_Timeout)
    );

    task automatic tick();
        @(posedge i_SysClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One received byte: done low for a cycle, then high; written on the next edge.
    task automatic send_byte(input logic [7:0] b);
        i_RxByte = b;
        i_RxDone = 1'b0;
        tick();
        i_RxDone = 1'b1;
        tick();
    endtask

    // Byte arrival and a consumer read completing on the same edge.
    task automatic xfer(input logic [7:0] b);
        i_RxByte = b;
        i_RxDone = 1'b0;
        i_Ready  = 1'b0;
        tick();
        i_RxDone = 1'b1;
        i_Ready  = 1'b1;
        check("xfer_head", o_Data, q[0]);
        tick();
        i_Ready = 1'b0;
        void'(q.pop_front());
        q.push_back(b);
        check("xfer_count", o_Count, 32'd16);
        check("xfer_ovf", o_Overflow, 32'd0);
    endtask

    initial begin
        i_Reset         = 1'b1;
        i_RxByte        = 8'h00;
        i_RxDone        = 1'b1;
        i_Ready         = 1'b0;
        i_ClearOverflow = 1'b0;
        tick();
        tick();

        // 1: reset state, idle-high done produces no write
        check("rst_valid", o_Valid, 32'd0);
        check("rst_count", o_Count, 32'd0);
        check("rst_full", o_Full, 32'd0);
        check("rst_ovf", o_Overflow, 32'd0);
        check("rst_tmo", o_Timeout, 32'd0);
        i_Reset = 1'b0;
        tick();
        tick();
        check("idle_nowrite", o_Count, 32'd0);

        // 2: three bytes, then drained on consecutive cycles
        send_byte(8'h55);
        check("w1_count", o_Count, 32'd1);
        check("w1_valid", o_Valid, 32'd1);
        send_byte(8'hA3);
        send_byte(8'h00);
        check("w3_count", o_Count, 32'd3);
        check("w3_head", o_Data, 32'h55);
        i_Ready = 1'b1;
        check("rd0", o_Data, 32'h55);
        tick();
        check("rd1", o_Data, 32'hA3);
        check("rd1_count", o_Count, 32'd2);
        tick();
        check("rd2", o_Data, 32'h00);
        tick();
        check("rd_empty_valid", o_Valid, 32'd0);
        check("rd_empty_count", o_Count, 32'd0);
        tick();
        check("ready_empty_count", o_Count, 32'd0);
        i_Ready = 1'b0;

        // 3: fill, overflow drop, drain, clear
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
        end
        check("fill_count", o_Count, 32'd16);
        check("fill_full", o_Full, 32'd1);
        check("fill_ovf", o_Overflow, 32'd0);
        send_byte(8'hFF);
        check("drop_ovf", o_Overflow, 32'd1);
        check("drop_count", o_Count, 32'd16);
        check("drop_full", o_Full, 32'd1);
        i_Ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_data", o_Data, 32'(i));
            tick();
        end
        i_Ready = 1'b0;
        check("drain_valid", o_Valid, 32'd0);
        check("drain_ovf_sticky", o_Overflow, 32'd1);
        i_ClearOverflow = 1'b1;
        tick();
        i_ClearOverflow = 1'b0;
        check("clr_ovf", o_Overflow, 32'd0);

        // 4: full with simultaneous write and read, then wrap traffic
        q.delete();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h10 + i));
            q.push_back(8'(8'h10 + i));
        end
        check("full2_count", o_Count, 32'd16);
        xfer(8'hEE);
        check("simul_full", o_Full, 32'd1);
        for (int k = 0; k < 20; k++) begin
            xfer(8'(8'h20 + k));
        end
        i_Ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("wrap_drain", o_Data, q[i]);
            tick();
        end
        i_Ready = 1'b0;
        check("wrap_empty", o_Valid, 32'd0);
        check("last_is_0x33", q[15], 32'h33);

        // 5: reset with 5 entries and overflow set
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(8'h40 + i));
        end
        i_Ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
        end
        i_Ready = 1'b0;
        check("pre_rst_count", o_Count, 32'd5);
        check("pre_rst_ovf", o_Overflow, 32'd1);
        check("pre_rst_head", o_Data, 32'h4B);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        check("mid_rst_count", o_Count, 32'd0);
        check("mid_rst_valid", o_Valid, 32'd0);
        check("mid_rst_ovf", o_Overflow, 32'd0);
        tick();

        // 6: idle timeout
        send_byte(8'h77);
        check("tmo_w_count", o_Count, 32'd1);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        for (int i = 1; i < 10; i++) begin
            tick();
            check("tmo_early", o_Timeout, 32'd0);
        end
        tick();
        check("tmo_hit", o_Timeout, 32'd1);
        tick();
        check("tmo_hold", o_Timeout, 32'd1);
        i_Ready = 1'b1;
        tick();
        i_Ready = 1'b0;
        check("tmo_clear", o_Timeout, 32'd0);
        check("tmo_read_empty", o_Valid, 32'd0);
`else
        for (int i = 0; i < 12; i++) begin
            tick();
            check("tmo_tied", o_Timeout, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
